// File: rtl/additive_voice.sv
// Additive-synthesis voice: once per sample period, sums up to HARMONICS sine partials
// from a shared LUT, each weighted by a linearly decaying amplitude, into an offset-binary sample.
module additive_voice #(
  parameter int unsigned HARMONICS       = 8,
  parameter int unsigned SAMPLE_INTERVAL = 1500,
  parameter int unsigned PHASE_WRAP      = 48000,
  parameter int unsigned LUT_SHIFT       = 5,
  parameter int unsigned LUT_AW          = 11,
  parameter int unsigned AMP_W           = 7,
  parameter int unsigned OUT_W           = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              frequency,
  input  logic [6:0]               harm_count,
  input  logic [AMP_W-1:0]         rolloff,
  output logic [LUT_AW-1:0]        lut_addr,
  input  logic signed [15:0]       lut_data,
  output logic [OUT_W-1:0]         sample_out,
  output logic                     sample_valid,
  output logic                     overrun
);

  localparam int unsigned TIMER_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int unsigned PH_W    = $clog2(PHASE_WRAP);
  localparam int unsigned HIDX_W  = (HARMONICS > 1) ? $clog2(HARMONICS) : 1;
  localparam int unsigned INC_W   = 24;
  localparam int unsigned AMP_MAX = (1 << AMP_W) - 1;
  localparam int unsigned MID     = 1 << (OUT_W - 1);
  localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PHASE, S_ADDR, S_WAIT1, S_WAIT2, S_MAC, S_NEXT, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [TIMER_W-1:0]       timer;
  logic [15:0]              freq_q;
  logic [6:0]               n_q, h_q, n_in;
  logic [AMP_W-1:0]         amp_q;
  logic [INC_W-1:0]         inc_q;
  logic signed [31:0]       acc_q;
  logic [PH_W-1:0]          p_q;
  logic [PH_W-1:0]          phase_mem [HARMONICS];

  logic                     tick, skip;
  logic [HIDX_W-1:0]        idx;
  logic [PH_W:0]            p_sum;
  logic [PH_W-1:0]          p_next;
  logic signed [31:0]       lut_ext, amp_ext, prod, mac_term;
  logic signed [32:0]       s_wide;
  logic [OUT_W-1:0]         s_clamped;

  assign tick = (timer == TIMER_W'(SAMPLE_INTERVAL - 1));
  assign n_in = (harm_count > 7'(HARMONICS)) ? 7'(HARMONICS) : harm_count;
  assign idx  = h_q[HIDX_W-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a tick always restarts the calculation
  always_comb begin
    state_d = state_q;
    if (tick) begin
      state_d = (n_in == 7'd0) ? S_DONE : S_PHASE;
    end else begin
      case (state_q)
        S_PHASE: state_d = skip ? S_NEXT : S_ADDR;
        S_ADDR:  state_d = S_WAIT1;
        S_WAIT1: state_d = S_WAIT2;
        S_WAIT2: state_d = S_MAC;
        S_MAC:   state_d = S_NEXT;
        S_NEXT:  state_d = ((h_q + 7'd1) == n_q) ? S_DONE : S_PHASE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath combinational terms: Nyquist/zero-amp skip, phase step, MAC term, output clamp
  always_comb begin
    skip     = (inc_q >= INC_W'(PHASE_WRAP / 2)) || (amp_q == '0);
    p_sum    = {1'b0, phase_mem[idx]} + (PH_W + 1)'(inc_q);
    p_next   = (p_sum >= (PH_W + 1)'(PHASE_WRAP)) ? PH_W'(p_sum - (PH_W + 1)'(PHASE_WRAP))
                                                  : PH_W'(p_sum);
    lut_ext  = 32'(lut_data);
    amp_ext  = signed'(32'(amp_q));
    prod     = lut_ext * amp_ext;
    mac_term = prod >>> AMP_W;
    s_wide   = 33'(acc_q) + signed'(33'(MID));
    if (s_wide < 33'sd0)                          s_clamped = '0;
    else if (s_wide > signed'(33'(OUT_MAX)))      s_clamped = OUT_W'(OUT_MAX);
    else                                          s_clamped = s_wide[OUT_W-1:0];
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      timer        <= '0;
      freq_q       <= '0;
      n_q          <= '0;
      h_q          <= '0;
      amp_q        <= '0;
      inc_q        <= '0;
      acc_q        <= '0;
      p_q          <= '0;
      lut_addr     <= '0;
      sample_out   <= OUT_W'(MID);
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < int'(HARMONICS); i++) phase_mem[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timer        <= tick ? '0 : timer + TIMER_W'(1);
      if (tick) begin
        overrun <= (state_q != S_IDLE);
        freq_q  <= frequency;
        n_q     <= n_in;
        amp_q   <= AMP_W'(AMP_MAX);
        inc_q   <= INC_W'(frequency);
        h_q     <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          S_PHASE: begin
            if (skip) begin
              phase_mem[idx] <= '0;
            end else begin
              phase_mem[idx] <= p_next;
              p_q            <= p_next;
            end
          end
          S_ADDR: lut_addr <= LUT_AW'(p_q >> LUT_SHIFT);
          S_MAC:  acc_q    <= acc_q + mac_term;
          S_NEXT: begin
            h_q   <= h_q + 7'd1;
            inc_q <= inc_q + INC_W'(freq_q);
            amp_q <= (amp_q > rolloff) ? amp_q - rolloff : '0;
          end
          S_DONE: begin
            sample_out   <= s_clamped;
            sample_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
